// File: rtl/result_tx_streamer.sv
// result_tx_streamer
//   Takes a snapshot of the flat N_ELEM x ELEM_W product matrix when load_i
//   pulses. It then streams the snapshot as bytes to uart_tx over the
//   start/busy handshake. Element 0 goes first. Within each element the bytes
//   go LSB-first, or MSB-first when MSB_FIRST is set.
//
//   Optional build macro: RESULT_TX_CHECKSUM_EN
//     defined   : one extra byte is sent after the data bytes. It is the XOR
//                 of all data bytes.
//     undefined : exactly N_ELEM*ELEM_W/8 bytes are sent.
//
// Ports
//   bclk        in   1              baud-domain clock
//   rst         in   1              asynchronous, active-high reset
//   load_i      in   1              capture result_i and start a stream (IDLE only)
//   result_i    in   N_ELEM*ELEM_W  element k at [k*ELEM_W +: ELEM_W]
//   tx_busy_i   in   1              uart_tx busy flag
//   tx_data_o   out  8              byte presented to uart_tx
//   tx_start_o  out  1              one-cycle start strobe to uart_tx
//   busy_o      out  1              stream in progress
//   done_o      out  1              one-cycle pulse after the final byte completes
//
// States
//   S_IDLE    | waiting for load_i
//   S_SEND    | byte ready, waiting for uart_tx to be idle before strobing
//   S_WAIT_HI | strobe issued, waiting for tx_busy_i to rise (byte accepted)
//   S_WAIT_LO | frame in flight, waiting for tx_busy_i to fall
//   S_DONE    | done_o pulse, back to idle

module result_tx_streamer #(
  parameter int N_ELEM    = 9,
  parameter int ELEM_W    = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic                       bclk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [N_ELEM*ELEM_W-1:0]   result_i,
  input  logic                       tx_busy_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_start_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int BPE = ELEM_W / 8;
  localparam int NB  = N_ELEM * BPE;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NB_TX = NB + 1;
`else
  localparam int NB_TX = NB;
`endif
  localparam int IDX_W = $clog2(NB_TX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_TX - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_start_q, tx_start_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [7:0]                 cur_byte;

  // Byte n of the stream, in transmit order, taken from a flat matrix.
  function automatic logic [7:0] pick(input logic [N_ELEM*ELEM_W-1:0] src,
                                      input int unsigned n);
    int unsigned e;
    int unsigned b;
    e = n / BPE;
    b = n % BPE;
    if (MSB_FIRST != 0) b = BPE - 1 - b;
    return src[e*ELEM_W + b*8 +: 8];
  endfunction

`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < NB; k++) csum = csum ^ pick(shadow_q, k);
  end

  always_comb begin
    if (idx_q == IDX_W'(NB)) cur_byte = csum;
    else                     cur_byte = pick(shadow_q, 32'(idx_q));
  end
`else
  always_comb cur_byte = pick(shadow_q, 32'(idx_q));
`endif

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          shadow_d = result_i;
          idx_d    = '0;
          busy_d   = 1'b1;
          // If uart_tx is already idle, strobe byte 0 straight from the
          // incoming matrix so the first start lands one cycle after load.
          if (!tx_busy_i) begin
            tx_data_d  = pick(result_i, 0);
            tx_start_d = 1'b1;
            state_d    = S_WAIT_HI;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!tx_busy_i) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy_i) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy_i) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_result_tx_streamer.sv
// Testbench for result_tx_streamer.
// Two instances share one clock: u_lsb (MSB_FIRST=0) and u_msb (MSB_FIRST=1).
// Each instance drives its own uart_tx model, which holds busy for 10 cycles
// per start strobe. The expected byte streams come from the element values,
// using plain shift/XOR arithmetic.

module tb_result_tx_streamer;

  localparam int N  = 9;
  localparam int W  = 16;
  localparam int NB = N * W / 8;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif

  logic bclk = 1'b0;
  logic rst;
  always #5 bclk = ~bclk;

  logic           load0, load1;
  logic [N*W-1:0] res0, res1;
  logic           txb0, txb1;
  logic [7:0]     txd0, txd1;
  logic           txs0, txs1;
  logic           busy0, busy1;
  logic           done0, done1;

  result_tx_streamer #(.N_ELEM(N), .ELEM_W(W), .MSB_FIRST(0)) u_lsb (
    .bclk(bclk), .rst(rst), .load_i(load0), .result_i(res0), .tx_busy_i(txb0),
    .tx_data_o(txd0), .tx_start_o(txs0), .busy_o(busy0), .done_o(done0));

  result_tx_streamer #(.N_ELEM(N), .ELEM_W(W), .MSB_FIRST(1)) u_msb (
    .bclk(bclk), .rst(rst), .load_i(load1), .result_i(res1), .tx_busy_i(txb1),
    .tx_data_o(txd1), .tx_start_o(txs1), .busy_o(busy1), .done_o(done1));

  // uart_tx models
  int         cnt0 = 0, cnt1 = 0;
  bit         hold0 = 1'b0;
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  int         done_n0 = 0, done_n1 = 0;
  int         viol = 0;

  assign txb0 = hold0 || (cnt0 > 0);
  assign txb1 = (cnt1 > 0);

  always @(posedge bclk) begin
    if (txs0) begin
      rxq0.push_back(txd0);
      if (txb0) viol++;
      cnt0 <= 10;
    end else if (cnt0 > 0) cnt0 <= cnt0 - 1;
    if (txs1) begin
      rxq1.push_back(txd1);
      if (txb1) viol++;
      cnt1 <= 10;
    end else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    if (done0) done_n0++;
    if (done1) done_n1++;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected transmit stream for a matrix under a given byte order.
  function automatic void build(input logic [N*W-1:0] r, input bit msb);
    logic [W-1:0] e;
    logic [7:0]   x;
    int           sh;
    x = 8'h00;
    expq.delete();
    for (int k = 0; k < N; k++) begin
      e = r[k*W +: W];
      for (int b = 0; b < W/8; b++) begin
        sh = msb ? (W/8 - 1 - b) : b;
        expq.push_back(8'((e >> (8*sh)) & 16'h00FF));
        x = x ^ 8'((e >> (8*sh)) & 16'h00FF);
      end
    end
`ifdef RESULT_TX_CHECKSUM_EN
    expq.push_back(x);
`endif
  endfunction

  task automatic chk_stream(input int c, input string tag);
    logic [7:0] got[$];
    int n;
    got = (c == 0) ? rxq0 : rxq1;
    chk({tag, " byte_count"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte[%0d]", tag, i), {24'h0, got[i]}, {24'h0, expq[i]});
  endtask

  task automatic clear_rx();
    rxq0.delete(); rxq1.delete();
    done_n0 = 0; done_n1 = 0;
  endtask

  task automatic pulse_load(input bit c0, input bit c1);
    @(posedge bclk); #1;
    load0 = c0; load1 = c1;
    @(posedge bclk); #1;
    load0 = 1'b0; load1 = 1'b0;
  endtask

  task automatic wait_done(input int c, input string tag);
    int n;
    n = 0;
    while (n < 2000 && ((c == 0) ? done_n0 : done_n1) == 0) begin
      @(posedge bclk); #1; n++;
    end
    chk({tag, " done_seen"}, ((c == 0) ? done_n0 : done_n1) != 0, 1);
  endtask

  task automatic wait_rx(input int sz, input string tag);
    int n;
    n = 0;
    while (n < 2000 && rxq0.size() < sz) begin
      @(posedge bclk); #1; n++;
    end
    chk({tag, " reached_byte"}, rxq0.size(), sz);
  endtask

  function automatic logic [N*W-1:0] rand_mat();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom_range(0, 65535));
    return r;
  endfunction

  logic [N*W-1:0] orig;
  int             sz;
  int             n;

  initial begin
    rst = 1'b1; load0 = 1'b0; load1 = 1'b0; res0 = '0; res1 = '0;
    repeat (3) @(posedge bclk);
    #1;
    chk("rst tx_data", txd0, 0);
    chk("rst tx_start", txs0, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst busy msb", busy1, 0);
    rst = 1'b0;

    // 1: elem k = 0x0100+k, LSB first
    for (int k = 0; k < N; k++) res0[k*W +: W] = 16'h0100 + 16'(k);
    orig = res0;
    clear_rx();
    pulse_load(1, 0);
    chk("t1 start_latency", txs0, 1);
    chk("t1 busy_after_load", busy0, 1);
    res0 = rand_mat();
    wait_done(0, "t1");
    chk("t1 busy_at_done", busy0, 0);
    repeat (5) @(posedge bclk);
    #1;
    build(orig, 0);
    chk_stream(0, "t1");
    chk("t1 done_count", done_n0, 1);

    // 2: MSB first, elem0 = ABCD
    res1 = '0; res1[W-1:0] = 16'hABCD;
    clear_rx();
    pulse_load(0, 1);
    wait_done(1, "t2");
    repeat (3) @(posedge bclk);
    #1;
    build(res1, 1);
    chk_stream(1, "t2");

    // 3: all 00FF
    for (int k = 0; k < N; k++) res0[k*W +: W] = 16'h00FF;
    clear_rx();
    pulse_load(1, 0);
    wait_done(0, "t3");
    repeat (3) @(posedge bclk);
    #1;
    build(res0, 0);
    chk_stream(0, "t3");
    chk("t3 done_count", done_n0, 1);

    // random matrices on both instances at once
    for (int it = 0; it < 3; it++) begin
      res0 = rand_mat(); res1 = rand_mat();
      clear_rx();
      pulse_load(1, 1);
      orig = res0;
      wait_done(0, "rnd lsb");
      wait_done(1, "rnd msb");
      repeat (3) @(posedge bclk);
      #1;
      build(orig, 0);
      chk_stream(0, $sformatf("rnd%0d lsb", it));
      build(res1, 1);
      chk_stream(1, $sformatf("rnd%0d msb", it));
    end

    // 4: second load during byte 5 is ignored
    res0 = rand_mat(); orig = res0;
    clear_rx();
    pulse_load(1, 0);
    wait_rx(5, "t4");
    res0 = ~orig;
    load0 = 1'b1;
    @(posedge bclk); #1;
    load0 = 1'b0;
    wait_done(0, "t4");
    repeat (5) @(posedge bclk);
    #1;
    build(orig, 0);
    chk_stream(0, "t4");
    chk("t4 done_count", done_n0, 1);

    // load in the same cycle as done: ignored
    res0 = rand_mat();
    clear_rx();
    pulse_load(1, 0);
    n = 0;
    while (n < 2000 && done0 !== 1'b1) begin @(posedge bclk); #1; n++; end
    chk("tdone done_pulse", done0, 1);
    load0 = 1'b1;
    @(posedge bclk); #1;
    load0 = 1'b0;
    repeat (20) @(posedge bclk);
    #1;
    chk("tdone busy_ignored", busy0, 0);
    chk("tdone no_restart", rxq0.size(), NTX);

    // 5: reset during WAIT_LO of byte 7
    res0 = rand_mat();
    clear_rx();
    pulse_load(1, 0);
    wait_rx(7, "t5");
    repeat (4) @(posedge bclk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5 rst tx_start", txs0, 0);
    chk("t5 rst busy", busy0, 0);
    chk("t5 rst done", done0, 0);
    @(posedge bclk); #1;
    rst = 1'b0;
    repeat (30) @(posedge bclk);
    #1;
    chk("t5 abandoned", rxq0.size(), 7);
    chk("t5 no_done", done_n0, 0);
    res0 = rand_mat(); orig = res0;
    clear_rx();
    pulse_load(1, 0);
    wait_done(0, "t5 fresh");
    repeat (3) @(posedge bclk);
    #1;
    build(orig, 0);
    chk_stream(0, "t5 fresh");

    // 6: tx_busy high at load for 20 cycles
    res0 = rand_mat(); orig = res0;
    clear_rx();
    hold0 = 1'b1;
    pulse_load(1, 0);
    repeat (20) @(posedge bclk);
    #1;
    chk("t6 withheld", rxq0.size() + int'(txs0), 0);
    chk("t6 busy", busy0, 1);
    @(negedge bclk);
    hold0 = 1'b0;
    @(posedge bclk); #1;
    chk("t6 start_after_fall", txs0, 1);
    wait_done(0, "t6");
    repeat (3) @(posedge bclk);
    #1;
    build(orig, 0);
    chk_stream(0, "t6");

    chk("start_while_busy", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
